// File: rtl/crypto_pkg.sv
// crypto_pkg: shared definitions for the CBC decrypt sequencer.
//   - state_t   : sequencer states (IDLE, ISSUE, WAIT, OUT)
//   - BLK_W     : cipher block width in bits
//   - ALGO_*    : algorithm select encoding seen by the block cores
package crypto_pkg;

    localparam int BLK_W = 128;

    localparam logic ALGO_AES = 1'b0;
    localparam logic ALGO_SM4 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/cbc_decrypt_ctrl.sv
// cbc_decrypt_ctrl: CBC decryption sequencer.
//   Takes 128-bit ciphertext blocks on the s_* stream, hands each one to an
//   external block core in decrypt mode (core_start/core_done), XORs the core
//   result with the previous ciphertext (or IV for the first block) and
//   presents the plaintext on the m_* stream.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   algo_sel            algorithm for a new frame (0 AES, 1 SM4)
//   iv_load, iv_in      load the chaining IV (only between frames)
//   err_clr             clear sticky error flags
//   s_valid/s_ready/s_data/s_last   ciphertext input stream
//   m_valid/m_ready/m_data/m_last   plaintext output stream
//   core_start/core_din/core_algo_sel/core_done/core_dout  block core link
//   busy, frame_active, blk_cnt     status
//   err_timeout, err_iv             sticky errors
//
// Stream handshakes: a beat transfers on a rising clk edge where valid and
// ready are both high; once valid is raised the source holds data/last
// stable until that edge. The core link is a one-cycle core_start pulse
// answered by a one-cycle core_done pulse.
module cbc_decrypt_ctrl
    import crypto_pkg::*;
#(
    parameter int TIMEOUT          = 64,
    parameter bit CLEAR_IV_ON_LAST = 1'b1,
    parameter int CNT_W            = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              algo_sel,
    input  logic              iv_load,
    input  logic [127:0]      iv_in,
    input  logic              err_clr,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [127:0]      s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [127:0]      m_data,
    output logic              m_last,
    output logic              core_start,
    output logic [127:0]      core_din,
    output logic              core_algo_sel,
    input  logic              core_done,
    input  logic [127:0]      core_dout,
    output logic              busy,
    output logic              frame_active,
    output logic [CNT_W-1:0]  blk_cnt,
    output logic              err_timeout,
    output logic              err_iv
);

    state_t             state;
    state_t             state_nxt;

    logic [BLK_W-1:0]   c_reg;     // ciphertext of the block in flight
    logic               l_reg;     // its last flag
    logic [BLK_W-1:0]   p_reg;     // plaintext waiting in OUT
    logic [BLK_W-1:0]   iv_reg;    // previous ciphertext (chaining value)
    logic [15:0]        timer;

    logic s_hs;
    logic m_hs;
    logic done_ok;
    logic timer_exp;
    logic iv_ok;

    assign s_hs      = s_valid & s_ready;
    assign m_hs      = m_valid & m_ready;
    // A done pulse in the expiry cycle still counts as completion.
    assign done_ok   = (state == ST_WAIT) && core_done;
    assign timer_exp = (state == ST_WAIT) && !core_done && (timer == 16'(TIMEOUT - 1));
    assign iv_ok     = (state == ST_IDLE) && !frame_active;

    assign core_din = c_reg;
    assign m_data   = p_reg;
    assign m_last   = m_valid & l_reg;
    assign busy     = (state != ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        core_start = 1'b0;
        m_valid    = 1'b0;
        case (state)
            ST_IDLE: begin
                // Gated with rst_n so every output reads 0 while reset is held.
                s_ready = rst_n;
                if (s_valid) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                core_start = 1'b1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    state_nxt = ST_OUT;
                end else if (timer_exp) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath, frame tracking and timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_reg         <= '0;
            l_reg         <= 1'b0;
            p_reg         <= '0;
            iv_reg        <= '0;
            timer         <= '0;
            core_algo_sel <= ALGO_AES;
            frame_active  <= 1'b0;
            blk_cnt       <= '0;
        end else begin
            if (iv_load && iv_ok) begin
                iv_reg <= iv_in;
            end

            if (s_hs) begin
                c_reg <= s_data;
                l_reg <= s_last;
                if (!frame_active) begin
                    core_algo_sel <= algo_sel;
                    frame_active  <= 1'b1;
                end
            end

            if (state == ST_ISSUE) begin
                timer <= '0;
            end else if (state == ST_WAIT) begin
                timer <= timer + 16'd1;
            end

            if (done_ok) begin
                p_reg  <= core_dout ^ iv_reg;
                iv_reg <= c_reg;
            end

            // Timed-out block is dropped; IV keeps the last good ciphertext.
            if (timer_exp) begin
                frame_active <= 1'b0;
                blk_cnt      <= '0;
            end

            if (m_hs) begin
                if (l_reg) begin
                    frame_active <= 1'b0;
                    blk_cnt      <= '0;
                    if (CLEAR_IV_ON_LAST) begin
                        iv_reg <= '0;
                    end
                end else begin
                    blk_cnt <= blk_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Sticky errors: a new event outranks err_clr in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout <= 1'b0;
            err_iv      <= 1'b0;
        end else begin
            if (timer_exp) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end

            if (iv_load && !iv_ok) begin
                err_iv <= 1'b1;
            end else if (err_clr) begin
                err_iv <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cbc_decrypt_ctrl.sv
// tb_cbc_decrypt_ctrl: directed bench for cbc_decrypt_ctrl with a stub core
// answering 4 cycles after core_start with core_din ^ {16{8'hA5}}.
module tb_cbc_decrypt_ctrl;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          algo_sel;
    logic          iv_load;
    logic [127:0]  iv_in;
    logic          err_clr;
    logic          s_valid;
    logic          s_ready;
    logic [127:0]  s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [127:0]  m_data;
    logic          m_last;
    logic          core_start;
    logic [127:0]  core_din;
    logic          core_algo_sel;
    logic          core_done;
    logic [127:0]  core_dout;
    logic          busy;
    logic          frame_active;
    logic [15:0]   blk_cnt;
    logic          err_timeout;
    logic          err_iv;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] KEY_PAT = {16{8'hA5}};

    always #5 clk = ~clk;

    cbc_decrypt_ctrl #(.TIMEOUT(64), .CLEAR_IV_ON_LAST(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .algo_sel(algo_sel), .iv_load(iv_load),
        .iv_in(iv_in), .err_clr(err_clr), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .core_start(core_start),
        .core_din(core_din), .core_algo_sel(core_algo_sel),
        .core_done(core_done), .core_dout(core_dout), .busy(busy),
        .frame_active(frame_active), .blk_cnt(blk_cnt),
        .err_timeout(err_timeout), .err_iv(err_iv)
    );

    // Stub block core
    logic          stub_en;
    logic          man_done;
    logic          stub_done;
    logic [127:0]  stub_dout;
    logic [2:0]    dly;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly       <= 3'd0;
            stub_done <= 1'b0;
            stub_dout <= '0;
        end else begin
            stub_done <= 1'b0;
            if (core_start && stub_en) begin
                dly <= 3'd3;
            end else if (dly != 3'd0) begin
                dly <= dly - 3'd1;
                if (dly == 3'd1) begin
                    stub_done <= 1'b1;
                    stub_dout <= core_din ^ KEY_PAT;
                end
            end
        end
    end

    assign core_done = stub_done | man_done;
    assign core_dout = stub_dout;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [127:0] d, input logic last);
        int n;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        n = 0;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s_ready", {127'd0, s_ready}, 128'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("start_latency", {127'd0, core_start}, 128'd1);
    endtask

    task automatic recv(input logic [127:0] exp_d, input logic exp_l, input logic [15:0] exp_cnt);
        int n;
        n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("m_valid", {127'd0, m_valid}, 128'd1);
        chk("m_data", m_data, exp_d);
        chk("m_last", {127'd0, m_last}, {127'd0, exp_l});
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("blk_cnt", {112'd0, blk_cnt}, {112'd0, exp_cnt});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        algo_sel = 1'b0;
        iv_load  = 1'b0;
        iv_in    = '0;
        err_clr  = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        m_ready  = 1'b0;
        stub_en  = 1'b1;
        man_done = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_s_ready", {127'd0, s_ready}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_m_valid", {127'd0, m_valid}, 128'd0);
        chk("rst_blk_cnt", {112'd0, blk_cnt}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_s_ready", {127'd0, s_ready}, 128'd1);

        // 1: single-block frame, IV = 0
        send(128'h1, 1'b1);
        recv(128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a4, 1'b1, 16'd0);
        chk("t1_frame_active", {127'd0, frame_active}, 128'd0);

        // 2: IV load then 3-block chained frame
        @(negedge clk);
        iv_load = 1'b1;
        iv_in   = {16{8'hF0}};
        @(negedge clk);
        iv_load = 1'b0;
        chk("t2_err_iv", {127'd0, err_iv}, 128'd0);
        send(128'h1, 1'b0);
        recv(128'h55555555555555555555555555555554, 1'b0, 16'd1);
        chk("t2_frame_active", {127'd0, frame_active}, 128'd1);
        send(128'h2, 1'b0);
        recv(128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a6, 1'b0, 16'd2);
        send(128'h3, 1'b1);
        recv(128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a4, 1'b1, 16'd0);

        // 3: back-pressure in OUT; IV cleared after last block
        send(128'h4, 1'b1);
        for (int i = 0; i < 50 && !m_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("t3_m_data", m_data, 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a1);
            chk("t3_s_ready", {127'd0, s_ready}, 128'd0);
            chk("t3_core_start", {127'd0, core_start}, 128'd0);
            @(negedge clk);
        end
        recv(128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a1, 1'b1, 16'd0);

        // 4: core never answers
        stub_en = 1'b0;
        send(128'h5, 1'b1);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk("t4_no_m_valid", {127'd0, m_valid}, 128'd0);
            chk("t4_err_early", {127'd0, err_timeout}, 128'd0);
        end
        @(negedge clk);
        chk("t4_err_timeout", {127'd0, err_timeout}, 128'd1);
        chk("t4_busy", {127'd0, busy}, 128'd0);
        chk("t4_frame_active", {127'd0, frame_active}, 128'd0);
        chk("t4_m_valid", {127'd0, m_valid}, 128'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t4_err_clr", {127'd0, err_timeout}, 128'd0);
        stub_en = 1'b1;

        // 5: iv_load and algo_sel change mid-frame
        algo_sel = 1'b1;
        send(128'h10, 1'b0);
        chk("t5_algo_latch", {127'd0, core_algo_sel}, 128'd1);
        recv(128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5b5, 1'b0, 16'd1);
        iv_load  = 1'b1;
        iv_in    = {128{1'b1}};
        algo_sel = 1'b0;
        @(negedge clk);
        iv_load = 1'b0;
        chk("t5_err_iv", {127'd0, err_iv}, 128'd1);
        send(128'h20, 1'b1);
        chk("t5_algo_hold", {127'd0, core_algo_sel}, 128'd1);
        recv(128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a595, 1'b1, 16'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t5_err_iv_clr", {127'd0, err_iv}, 128'd0);

        // 6: reset during WAIT, then a stray core_done
        send(128'h30, 1'b1);
        @(negedge clk);
        chk("t6_in_wait", {127'd0, busy}, 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", {127'd0, busy}, 128'd0);
        chk("t6_s_ready", {127'd0, s_ready}, 128'd0);
        chk("t6_core_din", core_din, 128'd0);
        chk("t6_core_start", {127'd0, core_start}, 128'd0);
        chk("t6_frame_active", {127'd0, frame_active}, 128'd0);
        chk("t6_algo", {127'd0, core_algo_sel}, 128'd0);
        chk("t6_m_data", m_data, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_no_m_valid", {127'd0, m_valid}, 128'd0);
            chk("t6_idle", {127'd0, busy}, 128'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
